// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC arctangent result checker.
package cordic_pkg;

   localparam int WIDTH     = 16;        // data width of operand/result halves
   localparam int ORDER     = 12;        // CORDIC iteration count
   localparam int LENGTH    = 256;       // samples per run
   localparam int TOL       = 2;         // max accepted |error| in LSBs
   localparam int MODE_ATAN = 2;         // core mode this checker targets
   localparam int DEPTH     = ORDER + 1; // operand-to-result latency in edges
   localparam int IDX_W     = 8;         // sample index width
   localparam int CNT_W     = 9;         // counters must reach LENGTH itself

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic [WIDTH-1:0] expected;
   } dl_entry_t;

   localparam int ENTRY_W = $bits(dl_entry_t);

   // Absolute difference of two signed WIDTH-bit values, computed one bit
   // wider so that the full range (up to 2^WIDTH - 1) never wraps.
   function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] got,
                                               input logic [WIDTH-1:0] exp_v);
      logic [WIDTH:0] d;
      d = {got[WIDTH-1], got} - {exp_v[WIDTH-1], exp_v};
      if (d[WIDTH]) begin
         return (~d) + (WIDTH+1)'(1);
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/cordic_delay_line.sv
// Fixed-depth shift register that carries expected values alongside the
// CORDIC pipeline so they arrive at the compare point with their results.
module cordic_delay_line #(
   parameter int DEPTH = 13,
   parameter int W     = 25
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         shift_en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage_r [DEPTH];

   // Shift one stage per enabled cycle; clear empties every stage at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else if (shift_en) begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/cordic_atan_checker.sv
// Result checker for the CORDIC core in arctangent mode: delays each golden
// value by the core latency, compares it with the core output within a
// tolerance and gathers pass/fail statistics over a run of LENGTH samples.
module cordic_atan_checker
   import cordic_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET_n,
   input  logic               start,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   expected,
   input  logic [2*WIDTH-1:0] results,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [8:0]         err_count,
   output logic [7:0]         first_err_idx,
   output logic [WIDTH-1:0]   first_err_got,
   output logic [WIDTH:0]     max_abs_err
);

   chk_state_t          state_r;
   chk_state_t          next_state_s;
   logic                run_entry_s;
   logic                accept_s;
   logic [CNT_W-1:0]    issued_cnt_r;
   logic [CNT_W-1:0]    checked_cnt_r;
   logic                first_flag_r;
   dl_entry_t           push_s;
   dl_entry_t           tail_s;
   logic [ENTRY_W-1:0]  push_bits_s;
   logic [ENTRY_W-1:0]  tail_bits_s;
   logic [WIDTH:0]      abs_err_s;
   logic                compare_s;
   logic                mismatch_s;
   logic                busy_s;
   logic                done_s;
   logic                pass_s;
   logic                unused_upper_s;

   // Only the low half of the core output bus carries the angle.
   assign unused_upper_s = ^results[2*WIDTH-1:WIDTH];

   // Start is honoured only outside RUN; a sample is taken while the run still needs one.
   assign run_entry_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign accept_s    = (state_r == RUN) && in_valid && (issued_cnt_r < CNT_W'(LENGTH));

   // State register.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: a run ends once every sample has been compared.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_state_s = RUN;
            else       next_state_s = IDLE;
         end
         RUN: begin
            if (checked_cnt_r == CNT_W'(LENGTH)) next_state_s = DONE;
            else                                 next_state_s = RUN;
         end
         DONE: begin
            if (start) next_state_s = RUN;
            else       next_state_s = DONE;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode from the next state so the status flags can be registered.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      pass_s = 1'b0;
      case (next_state_s)
         RUN:  busy_s = 1'b1;
         DONE: begin
            done_s = 1'b1;
            pass_s = (err_count == 9'd0);
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
            pass_s = 1'b0;
         end
      endcase
   end

   // Registered status flags.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
      end else begin
         busy <= busy_s;
         done <= done_s;
         pass <= pass_s;
      end
   end

   // Build the delay-line head entry; idle cycles push an invalid bubble.
   always_comb begin
      push_s = '0;
      if (accept_s) begin
         push_s.valid    = 1'b1;
         push_s.idx      = issued_cnt_r[IDX_W-1:0];
         push_s.expected = expected;
      end else begin
         push_s = '0;
      end
   end

   assign push_bits_s = push_s;
   assign tail_s      = dl_entry_t'(tail_bits_s);

   cordic_delay_line #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_delay (
      .clk      (CLK),
      .rst_n    (RESET_n),
      .clear    (run_entry_s),
      .shift_en (state_r == RUN),
      .din      (push_bits_s),
      .dout     (tail_bits_s)
   );

   // Compare the delayed golden value against the core output arriving now.
   always_comb begin
      abs_err_s  = abs_diff(results[WIDTH-1:0], tail_s.expected);
      compare_s  = (state_r == RUN) && tail_s.valid;
      mismatch_s = compare_s && (abs_err_s > (WIDTH+1)'(TOL));
   end

   // Count samples issued into the pipeline during the run.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         issued_cnt_r <= '0;
      end else if (run_entry_s) begin
         issued_cnt_r <= '0;
      end else if (accept_s) begin
         issued_cnt_r <= issued_cnt_r + CNT_W'(1);
      end else begin
         issued_cnt_r <= issued_cnt_r;
      end
   end

   // Accumulate run statistics at each compare edge.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         checked_cnt_r <= '0;
         err_count     <= '0;
         first_flag_r  <= 1'b0;
         first_err_idx <= '0;
         first_err_got <= '0;
         max_abs_err   <= '0;
      end else if (run_entry_s) begin
         checked_cnt_r <= '0;
         err_count     <= '0;
         first_flag_r  <= 1'b0;
         first_err_idx <= '0;
         first_err_got <= '0;
         max_abs_err   <= '0;
      end else if (compare_s) begin
         checked_cnt_r <= checked_cnt_r + CNT_W'(1);
         if (mismatch_s) begin
            err_count <= err_count + 9'd1;
         end else begin
            err_count <= err_count;
         end
         if (mismatch_s && !first_flag_r) begin
            first_flag_r  <= 1'b1;
            first_err_idx <= tail_s.idx;
            first_err_got <= results[WIDTH-1:0];
         end else begin
            first_flag_r  <= first_flag_r;
            first_err_idx <= first_err_idx;
            first_err_got <= first_err_got;
         end
         if (abs_err_s > max_abs_err) begin
            max_abs_err <= abs_err_s;
         end else begin
            max_abs_err <= max_abs_err;
         end
      end else begin
         checked_cnt_r <= checked_cnt_r;
      end
   end

endmodule

// File: tb/tb_cordic_atan_checker.sv
// Randomized self-checking bench for cordic_atan_checker. A model CORDIC pipe
// returns expected+injected error 13 edges after issue; run statistics are
// predicted from the list of issued (expected, result) pairs.
module tb_cordic_atan_checker;

   localparam int W   = 16;
   localparam int LEN = 256;
   localparam int LAT = 13;

   logic              clk = 1'b0;
   logic              RESET_n;
   logic              start;
   logic              in_valid;
   logic [W-1:0]      expected;
   logic [2*W-1:0]    results;
   logic              busy;
   logic              done;
   logic              pass;
   logic [8:0]        err_count;
   logic [7:0]        first_err_idx;
   logic [W-1:0]      first_err_got;
   logic [W:0]        max_abs_err;

   int                n_cmp = 0;
   int                n_bad = 0;
   int                tnum  = 0;
   int                err_arr [LEN];
   logic [W-1:0]      sched [int];

   cordic_atan_checker dut (
      .CLK           (clk),
      .RESET_n       (RESET_n),
      .start         (start),
      .in_valid      (in_valid),
      .expected      (expected),
      .results       (results),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_got (first_err_got),
      .max_abs_err   (max_abs_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint got, input longint exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL t%0d %s: got %0d expected %0d", tnum, tag, got, exp_v);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_pass"}, pass, 0);
      check_eq({tag, "_errcnt"}, err_count, 0);
      check_eq({tag, "_fidx"}, first_err_idx, 0);
      check_eq({tag, "_fgot"}, first_err_got, 0);
      check_eq({tag, "_maxerr"}, max_abs_err, 0);
   endtask

   task automatic clear_errs();
      for (int i = 0; i < LEN; i++) err_arr[i] = 0;
   endtask

   // One run: gap=1 issues on alternate cycles, abort_at>=0 resets after that
   // many accepts, special_idx forces expected=0x7FFF on that sample.
   task automatic run_test(input int gap, input int abort_at, input int special_idx);
      logic [W-1:0] exp_v [LEN];
      logic [W-1:0] res_v [LEN];
      logic [W-1:0] r;
      int acc, last_off, done_off;
      int m_err, m_first, m_got, m_max, d, ad;
      sched.delete();
      tnum++;
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; results = 32'($urandom);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("start_busy", busy, 1);
      check_eq("start_done", done, 0);
      check_eq("start_errcnt", err_count, 0);
      check_eq("start_maxerr", max_abs_err, 0);
      check_eq("start_fidx", first_err_idx, 0);
      check_eq("start_fgot", first_err_got, 0);
      acc = 0; last_off = 0; done_off = -1;
      for (int c = 1; c <= 1500 && done_off < 0; c++) begin
         in_valid = (gap != 0) ? ((c % 2) == 1) : 1'b1;
         expected = 16'($urandom_range(0, 60000)) - 16'd30000;
         if (acc == special_idx) expected = 16'h7FFF;
         if (in_valid && acc < LEN) begin
            r = expected + 16'(err_arr[acc]);
            exp_v[acc] = expected;
            res_v[acc] = r;
            sched[c + LAT] = r;
            last_off = c;
            acc++;
         end
         results = {16'($urandom), (sched.exists(c) ? sched[c] : 16'($urandom))};
         @(posedge clk);
         @(negedge clk);
         if (abort_at >= 0 && acc >= abort_at) begin
            RESET_n = 1'b0;
            #1;
            check_all_zero("midreset");
            @(negedge clk);
            RESET_n = 1'b1; start = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("post_reset_idle_busy", busy, 0);
            in_valid = 1'b0;
            return;
         end
         if (done) done_off = c;
      end
      in_valid = 1'b0;
      check_eq("done_offset", done_off, last_off + LAT + 1);
      check_eq("end_busy", busy, 0);
      m_err = 0; m_first = -1; m_got = 0; m_max = 0;
      for (int i = 0; i < LEN; i++) begin
         d  = int'($signed(res_v[i])) - int'($signed(exp_v[i]));
         ad = (d < 0) ? -d : d;
         if (ad > 2) begin
            m_err++;
            if (m_first < 0) begin
               m_first = i;
               m_got   = int'(res_v[i]);
            end
         end
         if (ad > m_max) m_max = ad;
      end
      check_eq("errcnt", err_count, m_err);
      check_eq("pass", pass, (m_err == 0) ? 1 : 0);
      check_eq("maxerr", max_abs_err, m_max);
      check_eq("fidx", first_err_idx, (m_first < 0) ? 0 : m_first);
      check_eq("fgot", first_err_got, m_got);
   endtask

   initial begin
      RESET_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      expected = '0; results = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      RESET_n = 1'b1;
      @(negedge clk);

      // clean continuous run
      clear_errs();
      run_test(0, -1, -1);

      // two corrupted samples
      clear_errs();
      err_arr[37]  = 5;
      err_arr[200] = -3;
      run_test(0, -1, -1);

      // every sample off by exactly +/-2
      clear_errs();
      for (int i = 0; i < LEN; i++) err_arr[i] = ($urandom_range(0, 1) != 0) ? 2 : -2;
      run_test(0, -1, -1);

      // single sample off by +3
      clear_errs();
      err_arr[$urandom_range(0, LEN-1)] = 3;
      run_test(0, -1, -1);

      // alternate-cycle issue
      clear_errs();
      run_test(1, -1, -1);

      // reset mid-run, then a clean run
      clear_errs();
      run_test(0, 100, -1);
      run_test(0, -1, -1);

      // extreme values: 0x7FFF expected, 0x8000 returned
      clear_errs();
      err_arr[50] = 1;
      run_test(0, -1, 50);

      // restart from DONE clears statistics
      clear_errs();
      run_test(0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cordic_atan_checker.md
# cordic_atan_checker

Synthesizable result checker for the CORDIC core in mode 2 (arctangent). It sits on the output side of the CORDIC pipeline, opposite the vector source that drives `operand`. It takes each expected arctangent value when its operand is issued and delays it by the core latency. It then compares that value against `results[WIDTH-1:0]` within a tolerance, and reports pass/fail statistics once a run of LENGTH samples completes. This allows on-chip and bench self-checking without a software comparison loop.

## Interface
- WIDTH, 16, data width of operand/result halves (signed, same Q-format as the core).
- ORDER, 12, CORDIC iteration count. The core latency from operand to result is ORDER+1 clock edges.
- LENGTH, 256, samples per run.
- TOL, 2, maximum accepted absolute error in LSBs.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a run. Honoured only in IDLE or DONE.
- in_valid  in  1  an operand and its expected value are being issued to the core this cycle.
- expected  in  WIDTH  signed golden atan for the operand issued this cycle.
- results  in  2*WIDTH  CORDIC output bus; bits [WIDTH-1:0] are checked.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- pass  out  1  done and err_count==0.
- err_count  out  9  number of mismatches in the run.
- first_err_idx  out  8  sample index of the first mismatch.
- first_err_got  out  WIDTH  result value at the first mismatch.
- max_abs_err  out  WIDTH+1  largest absolute error seen in the run.

## Operation
- States and transitions:
  - IDLE → RUN on start.
  - RUN → DONE when checked_cnt reaches LENGTH.
  - DONE → RUN on start.
  - There is no other exit.
- On entry to RUN, all of the following clear to 0: the delay line, issued_cnt, checked_cnt, err_count, first_err_idx, first_err_got, max_abs_err, and the first-error flag.
- Acceptance in RUN:
  - A sample is accepted when in_valid=1 and issued_cnt<LENGTH.
  - Each accepted sample pushes {valid=1, expected, idx=issued_cnt} into the delay line head.
  - Any cycle without an accepted sample pushes valid=0.
- Delay line: ORDER+1 stages. It shifts every cycle in RUN and holds its contents in IDLE and DONE.
- Comparison happens when the tail stage is valid:
  - diff = sign-extended results[WIDTH-1:0] minus sign-extended expected, computed at WIDTH+1 bits with no overflow.
  - The absolute value of diff is compared with TOL.
  - checked_cnt increments.
  - If |diff| is greater than TOL, err_count increments.
  - On the first mismatch only, first_err_idx and first_err_got are latched.
  - max_abs_err updates to max(max_abs_err, |diff|) on every valid compare.
- in_valid is ignored outside RUN and after LENGTH samples have been accepted.
- start is ignored while in RUN.
- Outputs retain their values in DONE until the next start.
- Reset, whether asserted mid-run or at any other time, forces IDLE.
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_got=0, max_abs_err=0, and the delay line is invalid.

## Timing
- start sampled at edge k → busy=1 after edge k. The first sample can be accepted at edge k+1.
- A sample accepted at edge n is compared against results sampled at edge n+ORDER+1.
- Statistics registers update at the compare edge.
- done rises one edge after the compare edge of the LENGTH-th sample. busy falls on that same edge.
- With back-to-back in_valid from edge k+1, done=1 after edge k+1+LENGTH+ORDER+1.
- Gaps in in_valid are allowed. Each sample still completes in exactly ORDER+1 edges.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `cordic_pkg`:
  - constants WIDTH, ORDER, LENGTH, and MODE_ATAN=2;
  - the checker state enum {IDLE, RUN, DONE};
  - a typedef for the delay-line entry {valid, idx[7:0], expected[WIDTH-1:0]}.
- One sub-module, `cordic_delay_line`, parameterized by DEPTH=ORDER+1 and the entry width, with a shift-enable input.
- The compare, statistics, and FSM logic stay in the top module.

## Test plan
- Reset held, then released; start pulsed; 256 samples with in_valid continuous, fed through a model pipe of latency 13 that returns exactly `expected` → done at k+270, pass=1, err_count=0, max_abs_err=0.
- Same run, with sample 37 corrupted by +5 and sample 200 by −3 → err_count=2, first_err_idx=37, first_err_got=expected[37]+5, max_abs_err=5, pass=0.
- Error of exactly ±2 on every sample → pass=1, max_abs_err=2. Error of +3 on one sample → err_count=1.
- in_valid toggled every other cycle → done only after the 256th compare, with the same results as the continuous run. in_valid held high after 256 accepts → no extra compares.
- RESET_n pulled low at sample 100 → all outputs 0 and state IDLE. Then start and a clean run → pass=1 with a full 256 compares.
- Extreme values: expected=0x7FFF with result=0x8000 → |diff|=65535 (no wrap), err_count=1. A second start in DONE clears all statistics.
